ix_queue: RTL and testbench

Decode-to-issue instruction queue. Buffers the 248-bit decoded bundles produced per instruction by the decoder wrapper and presents the two oldest entries in program order to the issue stage for up to dual in-order issue. It sits between decode and issue, absorbs issue-side stalls, and is cleared on pipeline flush (branch mispredict, trap, `fence.i`).

---
 rtl/ix_pkg.sv | 40 ++++
 rtl/ix_queue.sv | 87 ++++++++
 tb/tb_ix_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ix_pkg.sv
// rtl/ix_pkg.sv - decoded bundle width and field offsets shared by decode, issue queue and issue
package ix_pkg;

   localparam int IX_BUNDLE_W = 248;

   localparam int IX_PC_LSB       = 184;
   localparam int IX_PC_W         = 64;
   localparam int IX_BP           = 183;
   localparam int IX_BP_TRACK_LSB = 181;
   localparam int IX_BP_TRACK_W   = 2;
   localparam int IX_BT_LSB       = 117;
   localparam int IX_BT_W         = 64;
   localparam int IX_OP_LSB       = 113;
   localparam int IX_OP_W         = 4;
   localparam int IX_RD_LSB       = 108;
   localparam int IX_RS1_LSB      = 103;
   localparam int IX_RS2_LSB      = 98;
   localparam int IX_REG_W        = 5;
   localparam int IX_IMM_LSB      = 34;
   localparam int IX_IMM_W        = 64;
   localparam int IX_FU_LSB       = 30;
   localparam int IX_FU_W         = 4;
   localparam int IX_ALU_OP_LSB   = 24;
   localparam int IX_ALU_OP_W     = 6;
   localparam int IX_MEM_SIZE_LSB = 22;
   localparam int IX_MEM_SIZE_W   = 2;
   localparam int IX_MEM_SIGNED   = 21;
   localparam int IX_CSR_ADDR_LSB = 9;
   localparam int IX_CSR_ADDR_W   = 12;
   localparam int IX_CSR_OP_LSB   = 7;
   localparam int IX_CSR_OP_W     = 2;
   localparam int IX_LEGAL        = 6;
   localparam int IX_WB_EN        = 5;
   localparam int IX_IS_LOAD      = 4;
   localparam int IX_IS_STORE     = 3;
   localparam int IX_IS_BRANCH    = 2;
   localparam int IX_IS_JUMP      = 1;
   localparam int IX_FENCEI       = 0;

endpackage

// File: rtl/ix_queue.sv
// rtl/ix_queue.sv - decode-to-issue circular queue presenting the two oldest bundles for dual issue
module ix_queue
   import ix_pkg::*;
#(
   parameter int WIDTH = IX_BUNDLE_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         dec_ix_bundle,
   input  logic                     dec_ix_valid,
   output logic                     dec_ix_ready,
   output logic [WIDTH-1:0]         ix_bundle0,
   output logic                     ix_valid0,
   output logic [WIDTH-1:0]         ix_bundle1,
   output logic                     ix_valid1,
   input  logic                     ix_pop0,
   input  logic                     ix_pop1,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   ix_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_push;
   logic             w_valid0;
   logic             w_valid1;
   logic [1:0]       w_npop;
   logic [PW-1:0]    w_rd_ptr1;

   // Ready looks only at registered occupancy so no input reaches any output.
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_push    = dec_ix_valid & ~w_full;
   assign w_valid0  = (r_count != '0);
   assign w_valid1  = (r_count >= CW'(2));
   assign w_rd_ptr1 = r_rd_ptr + PW'(1);

   always_comb begin
      w_npop = 2'd0;
      if (ix_pop0 && ix_pop1 && w_valid1) begin
         w_npop = 2'd2;
      end else if (ix_pop0 && w_valid0) begin
         w_npop = 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PW'(w_npop);
         r_wr_ptr <= r_wr_ptr + PW'(w_push);
         r_count  <= r_count + CW'(w_push) - CW'(w_npop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push && !flush) begin
         r_mem[r_wr_ptr] <= dec_ix_bundle;
      end
   end

   assign dec_ix_ready = ~w_full;
   assign ix_valid0    = w_valid0;
   assign ix_valid1    = w_valid1;
   assign ix_bundle0   = r_mem[r_rd_ptr];
   assign ix_bundle1   = r_mem[w_rd_ptr1];
   assign ix_count     = r_count;

endmodule

// File: tb/tb_ix_queue.sv
// tb/tb_ix_queue.sv - directed self-checking bench for ix_queue
module tb_ix_queue;
   import ix_pkg::*;

   localparam int W = IX_BUNDLE_W;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] dec_ix_bundle;
   logic         dec_ix_valid;
   logic         dec_ix_ready;
   logic [W-1:0] ix_bundle0;
   logic         ix_valid0;
   logic [W-1:0] ix_bundle1;
   logic         ix_valid1;
   logic         ix_pop0;
   logic         ix_pop1;
   logic         flush;
   logic [2:0]   ix_count;

   int checks = 0;
   int errors = 0;

   ix_queue #(.WIDTH(W), .DEPTH(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dec_ix_bundle (dec_ix_bundle),
      .dec_ix_valid  (dec_ix_valid),
      .dec_ix_ready  (dec_ix_ready),
      .ix_bundle0    (ix_bundle0),
      .ix_valid0     (ix_valid0),
      .ix_bundle1    (ix_bundle1),
      .ix_valid1     (ix_valid1),
      .ix_pop0       (ix_pop0),
      .ix_pop1       (ix_pop1),
      .flush         (flush),
      .ix_count      (ix_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic [7:0] n);
      logic [W-1:0] b;
      b = '0;
      b[IX_PC_LSB +: IX_PC_W]   = 64'h8000_0000 + {54'd0, n, 2'b00};
      b[IX_OP_LSB +: IX_OP_W]   = n[3:0];
      b[IX_IMM_LSB +: IX_IMM_W] = {8{n}};
      b[IX_LEGAL]               = 1'b1;
      b[IX_FENCEI]              = n[0];
      return b;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] b, input logic p0, input logic p1, input logic f);
      dec_ix_valid  = v;
      dec_ix_bundle = b;
      ix_pop0       = p0;
      ix_pop1       = p1;
      flush         = f;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #12;
      check("rst_ready",   W'(dec_ix_ready), W'(1));
      check("rst_valid0",  W'(ix_valid0), W'(0));
      check("rst_valid1",  W'(ix_valid1), W'(0));
      check("rst_count",   W'(ix_count), W'(0));
      check("rst_bundle0", ix_bundle0, '0);
      check("rst_bundle1", ix_bundle1, '0);
      step();
      rst_n = 1'b1;

      // A, B, C on consecutive cycles
      drive(1'b1, mk(8'hA0), 1'b0, 1'b0, 1'b0);
      step();
      check("a_count",  W'(ix_count), W'(1));
      check("a_b0",     ix_bundle0, mk(8'hA0));
      check("a_valid1", W'(ix_valid1), W'(0));
      drive(1'b1, mk(8'hB0), 1'b0, 1'b0, 1'b0);
      step();
      check("b_count",  W'(ix_count), W'(2));
      check("b_b1",     ix_bundle1, mk(8'hB0));
      drive(1'b1, mk(8'hC0), 1'b0, 1'b0, 1'b0);
      step();
      check("c_count",  W'(ix_count), W'(3));
      check("c_b0",     ix_bundle0, mk(8'hA0));
      check("c_b1",     ix_bundle1, mk(8'hB0));
      check("c_ready",  W'(dec_ix_ready), W'(1));

      // fill, then blocked push with a pop in the same cycle
      drive(1'b1, mk(8'hD0), 1'b0, 1'b0, 1'b0);
      step();
      check("full_count", W'(ix_count), W'(4));
      check("full_ready", W'(dec_ix_ready), W'(0));
      drive(1'b1, mk(8'hEE), 1'b1, 1'b0, 1'b0);
      #1;
      check("blk_ready",  W'(dec_ix_ready), W'(0));
      step();
      check("blk_count",  W'(ix_count), W'(3));
      check("blk_ready2", W'(dec_ix_ready), W'(1));
      check("blk_b0",     ix_bundle0, mk(8'hB0));
      check("blk_b1",     ix_bundle1, mk(8'hC0));

      // queue B,C,D in slots 1..3; dual pop with push across the wrap
      drive(1'b1, mk(8'h04), 1'b1, 1'b1, 1'b0);
      step();
      check("dp1_count", W'(ix_count), W'(2));
      check("dp1_b0",    ix_bundle0, mk(8'hD0));
      check("dp1_b1",    ix_bundle1, mk(8'h04));
      drive(1'b1, mk(8'h05), 1'b1, 1'b1, 1'b0);
      step();
      check("dp2_count",  W'(ix_count), W'(1));
      check("dp2_b0",     ix_bundle0, mk(8'h05));
      check("dp2_valid1", W'(ix_valid1), W'(0));

      // pop1 alone is ignored; pop0+pop1 with one valid entry removes one
      drive(1'b1, mk(8'h06), 1'b0, 1'b0, 1'b0);
      step();
      check("p1_pre_count", W'(ix_count), W'(2));
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step();
      check("p1_count", W'(ix_count), W'(2));
      check("p1_b0",    ix_bundle0, mk(8'h05));
      check("p1_b1",    ix_bundle1, mk(8'h06));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step();
      check("p0_count", W'(ix_count), W'(1));
      check("p0_b0",    ix_bundle0, mk(8'h06));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      step();
      check("pu_count",  W'(ix_count), W'(0));
      check("pu_valid0", W'(ix_valid0), W'(0));

      // flush with concurrent push and pop
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(8'h10 + 8'(i)), 1'b0, 1'b0, 1'b0);
         step();
      end
      check("fl_pre_count", W'(ix_count), W'(3));
      drive(1'b1, mk(8'h20), 1'b1, 1'b0, 1'b1);
      step();
      check("fl_count",  W'(ix_count), W'(0));
      check("fl_valid0", W'(ix_valid0), W'(0));
      check("fl_valid1", W'(ix_valid1), W'(0));
      check("fl_ready",  W'(dec_ix_ready), W'(1));
      drive(1'b1, mk(8'h30), 1'b0, 1'b0, 1'b0);
      step();
      check("afl_count",  W'(ix_count), W'(1));
      check("afl_b0",     ix_bundle0, mk(8'h30));
      check("afl_valid1", W'(ix_valid1), W'(0));

      // asynchronous reset between edges
      drive(1'b1, mk(8'h31), 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, mk(8'h32), 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("ar_pre_count", W'(ix_count), W'(3));
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid0", W'(ix_valid0), W'(0));
      check("ar_valid1", W'(ix_valid1), W'(0));
      check("ar_count",  W'(ix_count), W'(0));
      check("ar_ready",  W'(dec_ix_ready), W'(1));
      step();
      rst_n = 1'b1;
      step();
      check("ar_post_count", W'(ix_count), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
